// File: rtl/mvm_stream_driver_if.sv
// Host byte-load port of the MVM stream driver.
// The host drives valid/data; the driver returns ready.
interface mvm_stream_driver_if #(
  parameter int WIDTH_IN = 8
);
  logic                ld_valid;
  logic [WIDTH_IN-1:0] ld_data;
  logic                ld_ready;

  modport master (
    output ld_valid,
    output ld_data,
    input  ld_ready
  );

  modport slave (
    input  ld_valid,
    input  ld_data,
    output ld_ready
  );
endinterface

// File: rtl/mvm_stream_driver.sv
// Buffers one x/A job, streams it to the serial MVM engine,
// then captures the serial y results into a host-readable file.
module mvm_stream_driver #(
  parameter int N_IN       = 20,
  parameter int N_OUT      = 4,
  parameter int WIDTH_IN   = 8,
  parameter int WIDTH_OUT  = 16,
  parameter int OUT_OFFSET = 1,
  parameter int TIMEOUT    = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  mvm_stream_driver_if.slave   ld,
  input  logic                 go,
  output logic                 mvm_start,
  output logic [WIDTH_IN-1:0]  mvm_data,
  input  logic                 mvm_done,
  input  logic [WIDTH_OUT-1:0] mvm_dout,
  output logic                 busy,
  output logic                 res_valid,
  input  logic [1:0]           res_addr,
  output logic [WIDTH_OUT-1:0] res_data,
  output logic                 timeout_err
);

  localparam int CW   = $clog2(N_IN + 1);
  localparam int IW   = $clog2(N_IN);
  localparam int OW   = $clog2(N_OUT);
  localparam int TMAX = (TIMEOUT > OUT_OFFSET) ? TIMEOUT : OUT_OFFSET;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_WAIT, S_SKIP, S_CAPTURE
  } state_e;

  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [WIDTH_IN-1:0] data_q, data_d;
  logic res_valid_q, res_valid_d;
  logic terr_q, terr_d;
  logic [N_OUT-1:0][WIDTH_OUT-1:0] res_q, res_d;
  logic [WIDTH_IN-1:0] mem_q [N_IN];
  logic mem_we;
  logic ld_ready_c;
  logic [IW-1:0] idx_nxt;

  assign ld_ready_c = (state_q == S_IDLE) &&
                      (count_q < CW'(N_IN));
  assign idx_nxt = idx_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    data_d      = data_q;
    res_valid_d = res_valid_q;
    terr_d      = terr_q;
    res_d       = res_q;
    mem_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (ld.ld_valid && ld_ready_c) begin
          mem_we  = 1'b1;
          count_d = count_q + CW'(1);
        end
        // go is judged against the count before this edge
        if (go && count_q == CW'(N_IN)) begin
          state_d     = S_START;
          res_valid_d = 1'b0;
          terr_d      = 1'b0;
        end
      end
      S_START: begin
        state_d = S_STREAM;
        idx_d   = '0;
        data_d  = mem_q[0];
      end
      S_STREAM: begin
        if (idx_q == IW'(N_IN - 1)) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end else begin
          idx_d  = idx_nxt;
          data_d = mem_q[idx_nxt];
        end
      end
      S_WAIT: begin
        if (mvm_done) begin
          tmr_d   = '0;
          idx_d   = '0;
          state_d = (OUT_OFFSET == 1) ? S_CAPTURE : S_SKIP;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          state_d     = S_IDLE;
          terr_d      = 1'b1;
          res_valid_d = 1'b0;
          count_d     = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_SKIP: begin
        if (tmr_q == TW'(OUT_OFFSET - 2)) begin
          state_d = S_CAPTURE;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CAPTURE: begin
        res_d[idx_q[OW-1:0]] = mvm_dout;
        if (idx_q == IW'(N_OUT - 1)) begin
          state_d     = S_IDLE;
          res_valid_d = 1'b1;
          count_d     = '0;
        end else begin
          idx_d = idx_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      tmr_q       <= '0;
      data_q      <= '0;
      res_valid_q <= 1'b0;
      terr_q      <= 1'b0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      data_q      <= data_d;
      res_valid_q <= res_valid_d;
      terr_q      <= terr_d;
      res_q       <= res_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[count_q] <= ld.ld_data;
    end
  end

  assign ld.ld_ready  = ld_ready_c;
  assign mvm_start    = (state_q == S_START);
  assign mvm_data     = data_q;
  assign busy         = (state_q != S_IDLE);
  assign res_valid    = res_valid_q;
  assign res_data     = res_q[res_addr];
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_mvm_stream_driver.sv
// Scoreboard bench: two drivers (result offset 1 and 3) share host
// stimulus, each talking to its own behavioural MVM engine.
module tb_mvm_stream_driver;
  localparam int TO   = 16;
  localparam int OFF0 = 1;
  localparam int OFF1 = 3;

  typedef struct packed {
    logic             tmo;
    logic [3:0][15:0] y;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       h_valid = 1'b0;
  logic [7:0] h_data = 8'h00;
  logic       go = 1'b0;
  logic [1:0] raddr0 = 2'd0;
  logic [1:0] raddr1 = 2'd0;

  logic [1:0] start_v, busy_v, rv_v, terr_v, done_v, ld_rdy;
  logic [1:0][7:0]  mdata_v;
  logic [1:0][15:0] dout_v, rdata_v;

  mvm_stream_driver_if #(.WIDTH_IN(8)) ld0 ();
  mvm_stream_driver_if #(.WIDTH_IN(8)) ld1 ();
  assign ld0.ld_valid = h_valid;
  assign ld0.ld_data  = h_data;
  assign ld1.ld_valid = h_valid;
  assign ld1.ld_data  = h_data;
  assign ld_rdy = {ld1.ld_ready, ld0.ld_ready};

  mvm_stream_driver #(.OUT_OFFSET(OFF0), .TIMEOUT(TO)) u0 (
    .clk(clk), .reset(reset), .ld(ld0), .go(go),
    .mvm_start(start_v[0]), .mvm_data(mdata_v[0]),
    .mvm_done(done_v[0]), .mvm_dout(dout_v[0]),
    .busy(busy_v[0]), .res_valid(rv_v[0]),
    .res_addr(raddr0), .res_data(rdata_v[0]),
    .timeout_err(terr_v[0])
  );

  mvm_stream_driver #(.OUT_OFFSET(OFF1), .TIMEOUT(TO)) u1 (
    .clk(clk), .reset(reset), .ld(ld1), .go(go),
    .mvm_start(start_v[1]), .mvm_data(mdata_v[1]),
    .mvm_done(done_v[1]), .mvm_dout(dout_v[1]),
    .busy(busy_v[1]), .res_valid(rv_v[1]),
    .res_addr(raddr1), .res_data(rdata_v[1]),
    .timeout_err(terr_v[1])
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t             sb [2][$];
  logic [19:0][7:0] bq [2][$];

  int  dly  = 1;
  bit  spur = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0][15:0] mvm(input logic [19:0][7:0] b);
    logic [3:0][15:0] y;
    for (int i = 0; i < 4; i++) begin
      int acc = 0;
      for (int k = 0; k < 4; k++) begin
        int a = int'($signed(b[4 + 4*i + k]));
        int x = int'($signed(b[k]));
        acc += a * x;
      end
      y[i] = acc[15:0];
    end
    return y;
  endfunction

  function automatic int off_of(input int j);
    return (j == 0) ? OFF0 : OFF1;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // behavioural engine per instance, evaluated mid-cycle
  int  rx_cnt [2];
  bit  rx_on [2];
  bit  prev_start [2];
  int  done_at [2];
  int  out_at [2];
  int  start_cyc [2];
  int  done_cyc [2];
  logic [19:0][7:0] rx [2];
  logic [3:0][15:0] ym [2];

  initial begin
    for (int j = 0; j < 2; j++) begin
      rx_on[j] = 0; rx_cnt[j] = 0; prev_start[j] = 0;
      done_at[j] = -1; out_at[j] = -100;
      start_cyc[j] = 0; done_cyc[j] = 0;
    end
    done_v = '0;
    dout_v = '0;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        if (!reset) begin
          rx_on[j] = 0; done_at[j] = -1; out_at[j] = -100;
        end else begin
          if (prev_start[j])
            chk($sformatf("start_pulse%0d", j), start_v[j], 1'b0);
          if (start_v[j]) begin
            rx_on[j] = 1; rx_cnt[j] = 0; start_cyc[j] = cyc;
          end else if (rx_on[j]) begin
            rx[j][rx_cnt[j]] = mdata_v[j];
            rx_cnt[j]++;
            if (rx_cnt[j] == 20) begin
              logic [19:0][7:0] eb;
              rx_on[j] = 0;
              n_tests++;
              if (bq[j].size() == 0) begin
                n_fail++;
                $display("FAIL stream%0d: got unexpected job, expected none", j);
              end else begin
                eb = bq[j].pop_front();
                if (rx[j] !== eb) begin
                  n_fail++;
                  $display("FAIL stream%0d: got %h expected %h", j, rx[j], eb);
                end
              end
              ym[j] = mvm(rx[j]);
              done_at[j] = (dly < 0) ? -1 : cyc + dly;
              out_at[j]  = (dly < 0) ? -100 : cyc + dly + off_of(j);
            end
          end
        end
        prev_start[j] = reset && start_v[j];
        done_v[j] = (done_at[j] >= 0 && cyc == done_at[j]) ||
                    (spur && rx_on[j] && rx_cnt[j] == 5);
        if (done_at[j] >= 0 && cyc == done_at[j]) done_cyc[j] = cyc;
        if (cyc >= out_at[j] && cyc < out_at[j] + 4)
          dout_v[j] = ym[j][cyc - out_at[j]];
        else
          dout_v[j] = 16'($urandom);
      end
    end
  end

  // result monitor
  bit   prev_rv [2];
  bit   prev_te [2];
  bit   mrise [2];
  exp_t me [2];

  initial begin
    prev_rv[0] = 0; prev_rv[1] = 0;
    prev_te[0] = 0; prev_te[1] = 0;
    forever begin
      @(negedge clk);
      for (int j = 0; j < 2; j++) begin
        mrise[j] = 0;
        if (reset && rv_v[j] && !prev_rv[j]) begin
          chk($sformatf("busy_at_res%0d", j), busy_v[j], 1'b0);
          chk($sformatf("res_latency%0d", j), cyc,
              done_cyc[j] + off_of(j) + 4);
          if (sb[j].size() == 0) begin
            chk($sformatf("unexpected_res%0d", j), 1, 0);
          end else begin
            me[j] = sb[j].pop_front();
            chk($sformatf("kind_res%0d", j), me[j].tmo, 1'b0);
            mrise[j] = 1;
          end
        end
        if (reset && terr_v[j] && !prev_te[j]) begin
          exp_t et;
          chk($sformatf("to_latency%0d", j), cyc, start_cyc[j] + 21 + TO);
          chk($sformatf("to_res_valid%0d", j), rv_v[j], 1'b0);
          chk($sformatf("to_ld_ready%0d", j), ld_rdy[j], 1'b1);
          if (sb[j].size() == 0) begin
            chk($sformatf("unexpected_to%0d", j), 1, 0);
          end else begin
            et = sb[j].pop_front();
            chk($sformatf("kind_to%0d", j), et.tmo, 1'b1);
          end
        end
        prev_rv[j] = rv_v[j];
        prev_te[j] = terr_v[j];
      end
      if (mrise[0] || mrise[1]) begin
        for (int a = 0; a < 4; a++) begin
          raddr0 = 2'(a);
          raddr1 = 2'(a);
          #1;
          for (int j = 0; j < 2; j++)
            if (mrise[j])
              chk($sformatf("res%0d_y%0d", j, a), rdata_v[j], me[j].y[a]);
        end
      end
    end
  end

  task automatic load20(input logic [19:0][7:0] b);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      h_valid = 1'b1;
      h_data  = b[i];
    end
    @(posedge clk); #1;
    h_valid = 1'b0;
  endtask

  task automatic run_job(input logic [19:0][7:0] b,
                         input logic [3:0][15:0] ey,
                         input int delay, input bit spurious,
                         input int extra);
    exp_t e;
    int k;
    dly  = delay;
    spur = spurious;
    e.tmo = (delay < 0);
    e.y   = ey;
    for (int j = 0; j < 2; j++) begin
      sb[j].push_back(e);
      bq[j].push_back(b);
    end
    if (extra == 0) begin
      load20(b);
      go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      chk("busy_on", busy_v, 2'b11);
    end else begin
      go = 1'b1;
      for (int i = 0; i < 20 + extra; i++) begin
        @(posedge clk); #1;
        h_valid = 1'b1;
        h_data  = (i < 20) ? b[i] : 8'($urandom);
        if (i >= 20) chk($sformatf("drop_ready%0d", i), ld_rdy, 2'b00);
      end
      @(posedge clk); #1;
      h_valid = 1'b0;
      go = 1'b0;
    end
    for (k = 0; k < 400; k++) begin
      if (busy_v == 2'b00) break;
      @(posedge clk); #1;
    end
    if (k == 400) chk("job_wait_bound", busy_v, 2'b00);
    repeat (3) @(posedge clk);
    #1;
  endtask

  logic [19:0][7:0] jb;
  logic [3:0][15:0] cy;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", start_v, 2'b00);
    chk("rst_data", mdata_v, 16'h0000);
    chk("rst_busy", busy_v, 2'b00);
    chk("rst_res_valid", rv_v, 2'b00);
    chk("rst_terr", terr_v, 2'b00);
    chk("rst_ld_ready", ld_rdy, 2'b11);
    chk("rst_res_data", rdata_v, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 20; i++) jb[i] = 8'(i);
    cy = {16'd110, 16'd86, 16'd62, 16'd38};
    run_job(jb, cy, 3, 1'b0, 0);

    for (int i = 0; i < 20; i++) jb[i] = 8'hFF;
    cy = {4{16'h0004}};
    run_job(jb, cy, 1, 1'b0, 0);

    for (int i = 0; i < 20; i++) jb[i] = 8'h80;
    cy = {4{16'h0000}};
    run_job(jb, cy, 5, 1'b0, 0);

    for (int i = 0; i < 20; i++) jb[i] = 8'($urandom);
    run_job(jb, mvm(jb), 4, 1'b0, 5);

    for (int i = 0; i < 20; i++) jb[i] = 8'($urandom);
    run_job(jb, '0, -1, 1'b0, 0);

    // abort mid-stream with reset
    for (int i = 0; i < 20; i++) jb[i] = 8'($urandom);
    dly = 3; spur = 1'b0;
    load20(jb);
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    chk("byte10_u0", mdata_v[0], jb[10]);
    chk("byte10_u1", mdata_v[1], jb[10]);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    chk("abort_start", start_v, 2'b00);
    chk("abort_data", mdata_v, 16'h0000);
    chk("abort_busy", busy_v, 2'b00);
    chk("abort_res_valid", rv_v, 2'b00);
    chk("abort_terr", terr_v, 2'b00);
    chk("abort_ld_ready", ld_rdy, 2'b11);
    chk("abort_res_data", rdata_v, 32'h0);
    @(posedge clk); #1;

    for (int i = 0; i < 20; i++) jb[i] = 8'($urandom);
    run_job(jb, mvm(jb), 2, 1'b0, 0);

    for (int i = 0; i < 20; i++) jb[i] = 8'(i);
    cy = {16'd110, 16'd86, 16'd62, 16'd38};
    run_job(jb, cy, 6, 1'b1, 0);

    for (int i = 0; i < 20; i++) jb[i] = 8'($urandom);
    run_job(jb, mvm(jb), TO, 1'b0, 0);

    for (int n = 0; n < 6; n++) begin
      for (int i = 0; i < 20; i++) jb[i] = 8'($urandom);
      run_job(jb, mvm(jb), int'($urandom_range(1, TO)),
              1'($urandom_range(0, 1)), 0);
    end

    repeat (5) @(posedge clk);
    chk("sb_empty", sb[0].size() + sb[1].size() +
        bq[0].size() + bq[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
